// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back arbiter: widths,
// requester indices and the {adr, data} write beat carried through the
// output stage.
package rf_pkg;

    localparam int DATA_W    = 16;
    localparam int ADR_W     = 2;
    localparam int REG_COUNT = 2 ** ADR_W;

    // Requester indices; also the bit positions in req/gnt vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    // One write-back beat as presented to the register file write port.
    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } wb_beat_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. On a tie the requester that was
// not granted last wins; rr_last only moves when the caller reports an
// accepted transfer through 'advance'. rr_last resets to REQ_LD so the ALU
// wins the first tie after reset.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_last;

    // Grant selection: single requester passes straight through, a tie
    // goes to the requester opposite rr_last.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = rr_last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

    // Remember the index of the last accepted grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last <= 1'b1;
        end else if (advance) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            rr_last <= gnt[REQ_LD];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// ALU write-back path (requester 0) and the load write-back path
// (requester 1). Round-robin grant, one registered output stage driving the
// write port, and a one-hot pending-write mask for decode stall logic.
// Optional feature: define RF_ARB_FORWARD_EN to add the fwd_adr/fwd_hit/
// fwd_data lookup against the staged write.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alu_valid,
    input  logic [ADR_W-1:0]     alu_adr,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 ld_valid,
    input  logic [ADR_W-1:0]     ld_adr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ready,
    output logic                 rf_write_en,
    output logic [ADR_W-1:0]     rf_write_adr,
    output logic [DATA_W-1:0]    rf_write_data,
    output logic [REG_COUNT-1:0] busy_mask
`ifdef RF_ARB_FORWARD_EN
    ,
    input  logic [ADR_W-1:0]     fwd_adr,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    wb_beat_t   beat_in;
    wb_beat_t   stage;

    // Requests are masked by flush (squash this cycle's acceptance) and by
    // reset (no ready may be raised while reset is held).
    assign req = (reset && !flush) ? {ld_valid, alu_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    // The register file takes a write every cycle, so a grant is always an
    // acceptance; readys never look at the output stage.
    assign accept    = |gnt;
    assign alu_ready = gnt[REQ_ALU];
    assign ld_ready  = gnt[REQ_LD];

    // Select the granted requester's beat for the output stage.
    always_comb begin
        beat_in = '{adr: alu_adr, data: alu_data};
        if (gnt[REQ_LD]) begin
            beat_in = '{adr: ld_adr, data: ld_data};
        end
    end

    // Output stage: load on acceptance, otherwise hold adr/data and drop
    // the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the staged adr/data are reset as well as the enable,
            // because they are visible outputs that must read 0 in reset.
            rf_write_en <= 1'b0;
            stage       <= '0;
        end else begin
            rf_write_en <= accept;
            if (accept) begin
                stage <= beat_in;
            end
        end
    end

    assign rf_write_adr  = stage.adr;
    assign rf_write_data = stage.data;

    // One-hot of the staged destination while the write is presented.
    always_comb begin
        busy_mask = '0;
        if (rf_write_en) begin
            busy_mask[rf_write_adr] = 1'b1;
        end
    end

`ifdef RF_ARB_FORWARD_EN
    // Forwarding lookup: the staged write satisfies a read of fwd_adr.
    always_comb begin
        fwd_hit  = rf_write_en && (rf_write_adr == fwd_adr);
        fwd_data = '0;
        if (fwd_hit) begin
            fwd_data = rf_write_data;
        end
    end
`else
    // Forwarding not built: no lookup ports and no comparator.
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a random
// run against a transaction-level model (pending request per requester,
// last-winner index, staged write). Define RF_ARB_FORWARD_EN to also cover
// the forwarding ports.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 flush = 1'b0;
    logic                 alu_valid = 1'b0;
    logic [ADR_W-1:0]     alu_adr = '0;
    logic [DATA_W-1:0]    alu_data = '0;
    logic                 alu_ready;
    logic                 ld_valid = 1'b0;
    logic [ADR_W-1:0]     ld_adr = '0;
    logic [DATA_W-1:0]    ld_data = '0;
    logic                 ld_ready;
    logic                 rf_write_en;
    logic [ADR_W-1:0]     rf_write_adr;
    logic [DATA_W-1:0]    rf_write_data;
    logic [REG_COUNT-1:0] busy_mask;
`ifdef RF_ARB_FORWARD_EN
    logic [ADR_W-1:0]     fwd_adr = '0;
    logic                 fwd_hit;
    logic [DATA_W-1:0]    fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .alu_valid     (alu_valid),
        .alu_adr       (alu_adr),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .ld_valid      (ld_valid),
        .ld_adr        (ld_adr),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_adr  (rf_write_adr),
        .rf_write_data (rf_write_data),
        .busy_mask     (busy_mask)
`ifdef RF_ARB_FORWARD_EN
        ,
        .fwd_adr       (fwd_adr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data)
`endif
    );

    task automatic drive(input logic av, input logic [ADR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic lv, input logic [ADR_W-1:0] la, input logic [DATA_W-1:0] ldd,
                         input logic fl);
        alu_valid = av; alu_adr = aa; alu_data = ad;
        ld_valid  = lv; ld_adr  = la; ld_data  = ldd;
        flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Pulse reset; returns at a falling edge with reset released.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'd1, 16'h1111, 1'b1, 2'd2, 16'h2222, 1'b0);
        @(posedge clk); #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", rf_write_en); end
        checks++; if (rf_write_adr !== '0) begin errors++; $display("FAIL reset_adr: got %0h want 0", rf_write_adr); end
        checks++; if (rf_write_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", rf_write_data); end
        checks++; if (busy_mask !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_mask); end
        @(negedge clk);
        idle();
        reset = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 2'd2, 16'h1234, 1'b0, '0, '0, 1'b0);
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b want 1", alu_ready); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL single_ld_ready: got %b want 0", ld_ready); end
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL single_en: got %b want 1", rf_write_en); end
        checks++; if (rf_write_adr !== 2'd2) begin errors++; $display("FAIL single_adr: got %0d want 2", rf_write_adr); end
        checks++; if (rf_write_data !== 16'h1234) begin errors++; $display("FAIL single_data: got %h want 1234", rf_write_data); end
        checks++; if (busy_mask !== 4'b0100) begin errors++; $display("FAIL single_busy: got %b want 0100", busy_mask); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL single_en_drop: got %b want 0", rf_write_en); end
        checks++; if (busy_mask !== 4'b0000) begin errors++; $display("FAIL single_busy_drop: got %b want 0000", busy_mask); end
        checks++; if (rf_write_adr !== 2'd2) begin errors++; $display("FAIL single_adr_hold: got %0d want 2", rf_write_adr); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        drive(1'b1, 2'd1, 16'hAAAA, 1'b1, 2'd3, 16'h5555, 1'b0);
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_adr !== 2'd1 || rf_write_data !== 16'hAAAA || rf_write_en !== 1'b1) begin
            errors++; $display("FAIL tie_write1: got en=%b adr=%0d data=%h want en=1 adr=1 data=aaaa", rf_write_en, rf_write_adr, rf_write_data); end
        @(negedge clk);
        drive(1'b0, 2'd1, 16'hAAAA, 1'b1, 2'd3, 16'h5555, 1'b0);
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL tie_second: got %b want 10", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_adr !== 2'd3 || rf_write_data !== 16'h5555 || rf_write_en !== 1'b1) begin
            errors++; $display("FAIL tie_write2: got en=%b adr=%0d data=%h want en=1 adr=3 data=5555", rf_write_en, rf_write_adr, rf_write_data); end
        checks++; if (busy_mask !== 4'b1000) begin errors++; $display("FAIL tie_busy2: got %b want 1000", busy_mask); end
        @(negedge clk);
        idle();
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b00) begin errors++; $display("FAIL tie_idle_ready: got %b want 00", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL tie_idle_en: got %b want 0", rf_write_en); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic exp_alu;
            logic [DATA_W-1:0] exp_data;
            exp_alu  = (i % 2 == 0);
            exp_data = exp_alu ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i);
            drive(1'b1, 2'd0, 16'h1000 + 16'(i), 1'b1, 2'd3, 16'h2000 + 16'(i), 1'b0);
            #1;
            checks++; if (alu_ready !== exp_alu || ld_ready !== !exp_alu) begin
                errors++; $display("FAIL b2b_ready[%0d]: got ld/alu=%b%b want %b%b", i, ld_ready, alu_ready, !exp_alu, exp_alu); end
            @(posedge clk); #1;
            checks++; if (rf_write_en !== 1'b1 || rf_write_data !== exp_data) begin
                errors++; $display("FAIL b2b_write[%0d]: got en=%b data=%h want en=1 data=%h", i, rf_write_en, rf_write_data, exp_data); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        // ALU wins once so the last winner is ALU.
        drive(1'b1, 2'd0, 16'h0101, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'd0, 16'h0202, 1'b1, 2'd2, 16'h0303, 1'b1);
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b00) begin errors++; $display("FAIL flush_ready: got %b want 00", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL flush_en: got %b want 0", rf_write_en); end
        @(negedge clk);
        drive(1'b1, 2'd0, 16'h0202, 1'b1, 2'd2, 16'h0303, 1'b0);
        #1;
        // Last winner still ALU, so the tie goes to LD.
        checks++; if ({ld_ready, alu_ready} !== 2'b10) begin errors++; $display("FAIL flush_after_ready: got %b want 10", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b1 || rf_write_adr !== 2'd2 || rf_write_data !== 16'h0303) begin
            errors++; $display("FAIL flush_after_write: got en=%b adr=%0d data=%h want en=1 adr=2 data=0303", rf_write_en, rf_write_adr, rf_write_data); end
        @(negedge clk);
        drive(1'b1, 2'd0, 16'h0202, 1'b0, '0, '0, 1'b0);
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL flush_loser_ready: got %b want 1", alu_ready); end
        @(posedge clk); #1;
        checks++; if (rf_write_data !== 16'h0202) begin errors++; $display("FAIL flush_loser_data: got %h want 0202", rf_write_data); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd1, 16'h7777, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL areset_pre_en: got %b want 1", rf_write_en); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (rf_write_en !== 1'b0 || rf_write_adr !== '0 || rf_write_data !== '0 || busy_mask !== '0) begin
            errors++; $display("FAIL areset_outputs: got en=%b adr=%0d data=%h busy=%b want all 0", rf_write_en, rf_write_adr, rf_write_data, busy_mask); end
        checks++; if ({ld_ready, alu_ready} !== 2'b00) begin errors++; $display("FAIL areset_ready: got %b want 00", {ld_ready, alu_ready}); end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 2'd1, 16'h1111, 1'b1, 2'd2, 16'h2222, 1'b0);
        #1;
        checks++; if ({ld_ready, alu_ready} !== 2'b01) begin errors++; $display("FAIL areset_tie: got %b want 01", {ld_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (rf_write_data !== 16'h1111) begin errors++; $display("FAIL areset_tie_data: got %h want 1111", rf_write_data); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_random();
        logic              pend_v[2];
        logic [ADR_W-1:0]  pend_adr[2];
        logic [DATA_W-1:0] pend_data[2];
        int                m_last;
        logic              m_en;
        logic [ADR_W-1:0]  m_adr;
        logic [DATA_W-1:0] m_data;
        do_reset();
        m_last = REQ_LD; m_en = 1'b0; m_adr = '0; m_data = '0;
        for (int r = 0; r < 2; r++) begin pend_v[r] = 1'b0; pend_adr[r] = '0; pend_data[r] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic fl;
            int g;
            logic [REG_COUNT-1:0] exp_busy;
            for (int r = 0; r < 2; r++) begin
                if (!pend_v[r] && $urandom_range(0, 2) != 0) begin
                    pend_v[r]    = 1'b1;
                    pend_adr[r]  = ADR_W'($urandom);
                    pend_data[r] = DATA_W'($urandom);
                end
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(pend_v[0], pend_adr[0], pend_data[0], pend_v[1], pend_adr[1], pend_data[1], fl);
`ifdef RF_ARB_FORWARD_EN
            fwd_adr = ADR_W'($urandom);
`endif
            // Expected winner: nobody under flush; the lone requester; on a
            // tie, whoever did not win last time.
            g = -1;
            if (!fl) begin
                if (pend_v[0] && pend_v[1]) g = 1 - m_last;
                else if (pend_v[0])         g = 0;
                else if (pend_v[1])         g = 1;
            end
            #1;
            checks++; if (alu_ready !== (g == 0) || ld_ready !== (g == 1)) begin
                errors++; $display("FAIL rand_ready[%0d]: got ld/alu=%b%b want winner %0d", cyc, ld_ready, alu_ready, g); end
            @(posedge clk);
            if (g >= 0) begin
                m_en = 1'b1; m_adr = pend_adr[g]; m_data = pend_data[g];
                m_last = g; pend_v[g] = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            exp_busy = '0;
            if (m_en) exp_busy[m_adr] = 1'b1;
            #1;
            checks++; if (rf_write_en !== m_en || rf_write_adr !== m_adr || rf_write_data !== m_data || busy_mask !== exp_busy) begin
                errors++; $display("FAIL rand_stage[%0d]: got en=%b adr=%0d data=%h busy=%b want en=%b adr=%0d data=%h busy=%b",
                                   cyc, rf_write_en, rf_write_adr, rf_write_data, busy_mask, m_en, m_adr, m_data, exp_busy); end
`ifdef RF_ARB_FORWARD_EN
            checks++; if (fwd_hit !== (m_en && m_adr == fwd_adr) || fwd_data !== ((m_en && m_adr == fwd_adr) ? m_data : '0)) begin
                errors++; $display("FAIL rand_fwd[%0d]: got hit=%b data=%h", cyc, fwd_hit, fwd_data); end
`endif
            @(negedge clk);
        end
        idle();
    endtask

`ifdef RF_ARB_FORWARD_EN
    task automatic test_forward();
        do_reset();
        drive(1'b1, 2'd1, 16'hBEEF, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        fwd_adr = 2'd1;
        #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hBEEF) begin
            errors++; $display("FAIL fwd_hit: got hit=%b data=%h want hit=1 data=beef", fwd_hit, fwd_data); end
        checks++; if (busy_mask !== 4'b0010) begin errors++; $display("FAIL fwd_busy: got %b want 0010", busy_mask); end
        fwd_adr = 2'd0;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin
            errors++; $display("FAIL fwd_miss: got hit=%b data=%h want hit=0 data=0000", fwd_hit, fwd_data); end
        @(negedge clk);
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef RF_ARB_FORWARD_EN
        test_forward();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
